// File: rtl/mem_ctrl_arbiter_if.sv
// Bundle of the fetch, MEM-stage and byte-wide RAM signals of mem_ctrl_arbiter.
// The slave modport is the arbiter's view; the master modport is the client and RAM view.
interface mem_ctrl_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush_in;
  logic              if_done;
  logic [DATA_W-1:0] if_data;
  logic              mem_read_req;
  logic              mem_write_req;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [DATA_W-1:0] mem_wdata_in;
  logic [2:0]        mem_len_in;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata_out;
  logic [1:0]        busy_state;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              io_buffer_full;

  modport slave (
    input  if_req, if_addr, flush_in, mem_read_req, mem_write_req, mem_addr_in,
    input  mem_wdata_in, mem_len_in, ram_din, io_buffer_full,
    output if_done, if_data, mem_done, mem_rdata_out, busy_state, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, flush_in, mem_read_req, mem_write_req, mem_addr_in,
    output mem_wdata_in, mem_len_in, ram_din, io_buffer_full,
    input  if_done, if_data, mem_done, mem_rdata_out, busy_state, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates one byte-wide RAM port between instruction fetch and the MEM stage.
// Optional MEMCTRL_IO_STALL_EN adds an IO_WAIT state that stalls IO-space stores while the IO buffer is full.
module mem_ctrl_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_ctrl_arbiter_if.slave bus
);

`ifdef MEMCTRL_IO_STALL_EN
  typedef enum logic [2:0] {IDLE = 3'd0, IF_RD = 3'd1, MEM_RD = 3'd2, MEM_WR = 3'd3, IO_WAIT = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, IF_RD = 3'd1, MEM_RD = 3'd2, MEM_WR = 3'd3} state_t;
`endif

  state_t            state_r;
  logic [2:0]        cnt_r;
  logic [2:0]        len_r;
  logic [ADDR_W-1:0] base_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] buf_r;

  logic              len_ok_s;
  logic              take_wr_s;
  logic              take_rd_s;
  logic              take_if_s;
  logic [2:0]        cnt_inc_s;
  logic [1:0]        idx_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [DATA_W-1:0] merged_s;
  logic [7:0]        next_byte_s;
`ifdef MEMCTRL_IO_STALL_EN
  logic [ADDR_W-1:0] cur_addr_s;
  logic [7:0]        cur_byte_s;
  logic              stall_first_s;
  logic              stall_next_s;
`endif

  // Request decode and byte-lane helpers; merged_s folds the byte arriving this cycle into the word.
  always_comb begin
    len_ok_s    = (bus.mem_len_in == 3'd1) || (bus.mem_len_in == 3'd2) || (bus.mem_len_in == 3'd4);
    take_wr_s   = bus.mem_write_req && len_ok_s;
    take_rd_s   = !take_wr_s && bus.mem_read_req && len_ok_s;
    take_if_s   = !take_wr_s && !take_rd_s && bus.if_req && !bus.flush_in;
    cnt_inc_s   = cnt_r + 3'd1;
    idx_s       = cnt_r[1:0] - 2'd1;
    next_addr_s = base_r + ADDR_W'(cnt_inc_s);
    merged_s    = buf_r | ({{(DATA_W-8){1'b0}}, bus.ram_din} << {idx_s, 3'b000});
    next_byte_s = 8'(wdata_r >> {cnt_inc_s[1:0], 3'b000});
`ifdef MEMCTRL_IO_STALL_EN
    cur_addr_s    = base_r + ADDR_W'(cnt_r);
    cur_byte_s    = 8'(wdata_r >> {cnt_r[1:0], 3'b000});
    stall_first_s = bus.io_buffer_full && (bus.mem_addr_in[17:16] == 2'b11);
    stall_next_s  = bus.io_buffer_full && (next_addr_s[17:16] == 2'b11);
`endif
  end

  // Single FSM: every output is a register updated alongside the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r           <= IDLE;
      cnt_r             <= 3'd0;
      len_r             <= 3'd0;
      base_r            <= '0;
      wdata_r           <= '0;
      buf_r             <= '0;
      bus.if_done       <= 1'b0;
      bus.if_data       <= '0;
      bus.mem_done      <= 1'b0;
      bus.mem_rdata_out <= '0;
      bus.busy_state    <= 2'b00;
      bus.ram_a         <= '0;
      bus.ram_dout      <= 8'h00;
      bus.ram_wr        <= 1'b0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (take_wr_s) begin
            state_r        <= MEM_WR;
            bus.busy_state <= 2'b10;
            cnt_r          <= 3'd0;
            len_r          <= bus.mem_len_in;
            base_r         <= bus.mem_addr_in;
            wdata_r        <= bus.mem_wdata_in;
`ifdef MEMCTRL_IO_STALL_EN
            if (stall_first_s) begin
              state_r      <= IO_WAIT;
              bus.ram_a    <= '0;
              bus.ram_dout <= 8'h00;
              bus.ram_wr   <= 1'b0;
            end else begin
              bus.ram_a    <= bus.mem_addr_in;
              bus.ram_dout <= bus.mem_wdata_in[7:0];
              bus.ram_wr   <= 1'b1;
            end
`else
            bus.ram_a    <= bus.mem_addr_in;
            bus.ram_dout <= bus.mem_wdata_in[7:0];
            bus.ram_wr   <= 1'b1;
`endif
          end else if (take_rd_s) begin
            state_r        <= MEM_RD;
            bus.busy_state <= 2'b10;
            cnt_r          <= 3'd0;
            len_r          <= bus.mem_len_in;
            base_r         <= bus.mem_addr_in;
            buf_r          <= '0;
            bus.ram_a      <= bus.mem_addr_in;
            bus.ram_dout   <= 8'h00;
            bus.ram_wr     <= 1'b0;
          end else if (take_if_s) begin
            state_r        <= IF_RD;
            bus.busy_state <= 2'b01;
            cnt_r          <= 3'd0;
            len_r          <= 3'd4;
            base_r         <= bus.if_addr;
            buf_r          <= '0;
            bus.ram_a      <= bus.if_addr;
            bus.ram_dout   <= 8'h00;
            bus.ram_wr     <= 1'b0;
          end else begin
            bus.busy_state <= 2'b00;
            bus.ram_a      <= '0;
            bus.ram_dout   <= 8'h00;
            bus.ram_wr     <= 1'b0;
          end
        end
        IF_RD, MEM_RD: begin
          bus.ram_dout <= 8'h00;
          bus.ram_wr   <= 1'b0;
          if ((state_r == IF_RD) && bus.flush_in) begin
            state_r        <= IDLE;
            bus.busy_state <= 2'b00;
            bus.ram_a      <= '0;
          end else begin
            if (cnt_r != 3'd0) begin
              buf_r <= merged_s;
            end else begin
              buf_r <= buf_r;
            end
            // cnt_r == len_r is the cycle the last byte arrives on ram_din.
            if (cnt_r == len_r) begin
              if (state_r == IF_RD) begin
                bus.if_done <= 1'b1;
                bus.if_data <= merged_s;
              end else begin
                bus.mem_done      <= 1'b1;
                bus.mem_rdata_out <= merged_s;
              end
              state_r        <= IDLE;
              bus.busy_state <= 2'b00;
              bus.ram_a      <= '0;
            end else begin
              cnt_r     <= cnt_inc_s;
              bus.ram_a <= (cnt_inc_s < len_r) ? next_addr_s : '0;
            end
          end
        end
        MEM_WR: begin
          if (cnt_inc_s == len_r) begin
            bus.mem_done   <= 1'b1;
            state_r        <= IDLE;
            bus.busy_state <= 2'b00;
            bus.ram_a      <= '0;
            bus.ram_dout   <= 8'h00;
            bus.ram_wr     <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
`ifdef MEMCTRL_IO_STALL_EN
            if (stall_next_s) begin
              state_r      <= IO_WAIT;
              bus.ram_a    <= '0;
              bus.ram_dout <= 8'h00;
              bus.ram_wr   <= 1'b0;
            end else begin
              bus.ram_a    <= next_addr_s;
              bus.ram_dout <= next_byte_s;
              bus.ram_wr   <= 1'b1;
            end
`else
            bus.ram_a    <= next_addr_s;
            bus.ram_dout <= next_byte_s;
            bus.ram_wr   <= 1'b1;
`endif
          end
        end
`ifdef MEMCTRL_IO_STALL_EN
        IO_WAIT: begin
          if (!bus.io_buffer_full) begin
            state_r      <= MEM_WR;
            bus.ram_a    <= cur_addr_s;
            bus.ram_dout <= cur_byte_s;
            bus.ram_wr   <= 1'b1;
          end else begin
            bus.ram_a    <= '0;
            bus.ram_dout <= 8'h00;
            bus.ram_wr   <= 1'b0;
          end
        end
`endif
        default: begin
          state_r        <= IDLE;
          bus.busy_state <= 2'b00;
          bus.ram_a      <= '0;
          bus.ram_dout   <= 8'h00;
          bus.ram_wr     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Self-checking bench for mem_ctrl_arbiter: directed timing scenarios plus randomized
// loads, stores and fetches checked against cycle expectations derived from the access rules.
module tb_mem_ctrl_arbiter;
  logic clk_in = 1'b0;
  logic rst_in;
  int   total = 0;
  int   bad = 0;

  mem_ctrl_arbiter_if bus ();

  mem_ctrl_arbiter dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural byte RAM: read data one cycle after the address, writes on the edge.
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk_in) begin
    bus.ram_din <= rd(bus.ram_a);
    if (bus.ram_wr === 1'b1) ram[bus.ram_a] = bus.ram_dout;
  end

  // {busy_state, ram_wr, ram_a, ram_dout, mem_done, if_done}
  function automatic logic [44:0] obs_vec();
    return {bus.busy_state, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.mem_done, bus.if_done};
  endfunction

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.flush_in = 1'b0;
    bus.mem_read_req = 1'b0; bus.mem_write_req = 1'b0; bus.mem_addr_in = 32'h0;
    bus.mem_wdata_in = 32'h0; bus.mem_len_in = 3'd0; bus.io_buffer_full = 1'b0;
  endtask

  task automatic fill(input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++) ram[addr + 32'(i)] = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [108:0] o;
    rst_in = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    o = {obs_vec(), bus.if_data, bus.mem_rdata_out};
    total++;
    if (o !== 109'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
    #1 rst_in = 1'b0;
    @(posedge clk_in); #1;
    total++;
    if (obs_vec() !== 45'd0) begin bad++; $display("FAIL idle_after_reset got=%h want=0", obs_vec()); end
  endtask

  // kind 0=load, 1=store, 2=fetch; checks every cycle from T+1 to one past the done cycle
  task automatic run_access(input int kind, input logic [31:0] addr, input int len, input logic [31:0] wdata);
    logic [31:0] exp_data, got;
    logic [44:0] exp_v;
    logic [1:0]  bsy;
    logic [7:0]  wb;
    logic        wr;
    int          done_at;
    exp_data = 32'h0;
    for (int i = 0; i < len; i++) exp_data = exp_data | (32'(rd(addr + 32'(i))) << (8 * i));
    @(posedge clk_in); #1;
    if (kind == 0) begin bus.mem_read_req = 1'b1; bus.mem_addr_in = addr; bus.mem_len_in = 3'(len); end
    if (kind == 1) begin
      bus.mem_write_req = 1'b1; bus.mem_addr_in = addr; bus.mem_len_in = 3'(len); bus.mem_wdata_in = wdata;
    end
    if (kind == 2) begin bus.if_req = 1'b1; bus.if_addr = addr; end
    @(posedge clk_in); #1;
    bus.mem_read_req = 1'b0; bus.mem_write_req = 1'b0;
    done_at = (kind == 1) ? len + 1 : len + 2;
    for (int k = 1; k <= done_at + 1; k++) begin
      @(negedge clk_in);
      bsy = (k < done_at) ? ((kind == 2) ? 2'b01 : 2'b10) : 2'b00;
      wr  = (kind == 1) && (k <= len);
      wb  = wr ? 8'(wdata >> (8 * (k - 1))) : 8'h00;
      exp_v = {bsy, wr, (k <= len) ? addr + 32'(k - 1) : 32'h0, wb,
               (kind != 2) && (k == done_at), (kind == 2) && (k == done_at)};
      total++;
      if (obs_vec() !== exp_v)
        begin bad++; $display("FAIL access_cycle kind=%0d len=%0d k=%0d got=%h want=%h", kind, len, k, obs_vec(), exp_v); end
      if (kind != 1 && k >= done_at) begin
        got = (kind == 2) ? bus.if_data : bus.mem_rdata_out;
        total++;
        if (got !== exp_data) begin bad++; $display("FAIL read_data kind=%0d k=%0d got=%h want=%h", kind, k, got, exp_data); end
      end
      if (kind == 2 && k == done_at) bus.if_req = 1'b0;
    end
    if (kind == 1) begin
      for (int i = 0; i < len; i++) begin
        total++;
        if (rd(addr + 32'(i)) !== 8'(wdata >> (8 * i)))
          begin bad++; $display("FAIL store_byte i=%0d got=%h want=%h", i, rd(addr + 32'(i)), 8'(wdata >> (8 * i))); end
      end
    end
  endtask

  task automatic test_directed();
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h203] = 8'h80;
    run_access(0, 32'h100, 4, 32'h0);
    total++;
    if (bus.mem_rdata_out !== 32'h44332211) begin bad++; $display("FAIL lw_value got=%h want=44332211", bus.mem_rdata_out); end
    run_access(0, 32'h203, 1, 32'h0);
    total++;
    if (bus.mem_rdata_out !== 32'h00000080) begin bad++; $display("FAIL lb_value got=%h want=00000080", bus.mem_rdata_out); end
    run_access(1, 32'h40, 2, 32'hABCD1234);
    fill(32'h104, 2);
    run_access(0, 32'h104, 2, 32'h0);
    fill(32'h1F0, 4);
    run_access(2, 32'h1F0, 4, 32'h0);
  endtask

  task automatic test_wrap();
    fill(32'hFFFF_FFFE, 2);
    fill(32'h0, 2);
    run_access(0, 32'hFFFF_FFFE, 4, 32'h0);
    run_access(1, 32'hFFFF_FFFF, 2, 32'h1357_9BDF);
  endtask

  task automatic test_priority();
    logic [31:0] ea, eb;
    logic [44:0] exp_v;
    logic [1:0]  bsy;
    logic [31:0] a;
    fill(32'h500, 4);
    fill(32'h600, 4);
    ea = {rd(32'h503), rd(32'h502), rd(32'h501), rd(32'h500)};
    eb = {rd(32'h603), rd(32'h602), rd(32'h601), rd(32'h600)};
    @(posedge clk_in); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    bus.mem_read_req = 1'b1; bus.mem_addr_in = 32'h500; bus.mem_len_in = 3'd4;
    @(posedge clk_in); #1;
    bus.mem_read_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk_in);
      bsy = (k <= 5) ? 2'b10 : ((k >= 7 && k <= 11) ? 2'b01 : 2'b00);
      a = (k <= 4) ? 32'h500 + 32'(k - 1) : ((k >= 7 && k <= 10) ? 32'h600 + 32'(k - 7) : 32'h0);
      exp_v = {bsy, 1'b0, a, 8'h00, k == 6, k == 12};
      total++;
      if (obs_vec() !== exp_v) begin bad++; $display("FAIL priority_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_v); end
      if (k == 6) begin
        total++;
        if (bus.mem_rdata_out !== ea) begin bad++; $display("FAIL priority_mem_data got=%h want=%h", bus.mem_rdata_out, ea); end
      end
      if (k == 12) begin
        total++;
        if (bus.if_data !== eb) begin bad++; $display("FAIL priority_if_data got=%h want=%h", bus.if_data, eb); end
        bus.if_req = 1'b0;
      end
    end
    // store wins over a simultaneous load
    @(posedge clk_in); #1;
    bus.mem_read_req = 1'b1; bus.mem_write_req = 1'b1; bus.mem_addr_in = 32'h700;
    bus.mem_len_in = 3'd1; bus.mem_wdata_in = 32'h0000_005A;
    @(posedge clk_in); #1;
    bus.mem_read_req = 1'b0; bus.mem_write_req = 1'b0;
    @(negedge clk_in);
    total++;
    if (obs_vec() !== {2'b10, 1'b1, 32'h700, 8'h5A, 1'b0, 1'b0})
      begin bad++; $display("FAIL write_over_read got=%h want=%h", obs_vec(), {2'b10, 1'b1, 32'h700, 8'h5A, 2'b00}); end
    @(negedge clk_in);
    total++;
    if (obs_vec() !== {2'b00, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0})
      begin bad++; $display("FAIL write_over_read_done got=%h want=%h", obs_vec(), {2'b00, 1'b0, 32'h0, 8'h00, 2'b10}); end
  endtask

  task automatic test_flush();
    logic [31:0] e80, a;
    logic [44:0] exp_v;
    logic [1:0]  bsy;
    fill(32'h80, 4);
    e80 = {rd(32'h83), rd(32'h82), rd(32'h81), rd(32'h80)};
    @(posedge clk_in); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    @(posedge clk_in); #1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_in);
      bsy = (k <= 3 || (k >= 5 && k <= 9)) ? 2'b01 : 2'b00;
      a = (k <= 3) ? 32'(k - 1) : ((k >= 5 && k <= 8) ? 32'h80 + 32'(k - 5) : 32'h0);
      exp_v = {bsy, 1'b0, a, 8'h00, 1'b0, k == 10};
      total++;
      if (obs_vec() !== exp_v) begin bad++; $display("FAIL flush_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_v); end
      if (k == 3) begin bus.flush_in = 1'b1; bus.if_addr = 32'h80; end
      if (k == 4) bus.flush_in = 1'b0;
      if (k == 10) begin
        total++;
        if (bus.if_data !== e80) begin bad++; $display("FAIL flush_refetch_data got=%h want=%h", bus.if_data, e80); end
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_bad_len();
    logic [2:0] lens [2] = '{3'd3, 3'd0};
    for (int j = 0; j < 2; j++) begin
      @(posedge clk_in); #1;
      bus.mem_read_req = 1'b1; bus.mem_addr_in = 32'h900; bus.mem_len_in = lens[j];
      @(posedge clk_in); #1;
      bus.mem_read_req = 1'b0;
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk_in);
        total++;
        if (obs_vec() !== 45'd0) begin bad++; $display("FAIL bad_len len=%0d k=%0d got=%h want=0", lens[j], k, obs_vec()); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [44:0] exp_v;
    @(posedge clk_in); #1;
    bus.mem_write_req = 1'b1; bus.mem_addr_in = 32'h300; bus.mem_len_in = 3'd4; bus.mem_wdata_in = 32'hDEAD_BEEF;
    @(posedge clk_in); #1;
    bus.mem_write_req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_in);
      exp_v = (k <= 2) ? {2'b10, 1'b1, 32'h300 + 32'(k - 1), 8'(32'hDEAD_BEEF >> (8 * (k - 1))), 2'b00} : 45'd0;
      total++;
      if (obs_vec() !== exp_v) begin bad++; $display("FAIL reset_mid k=%0d got=%h want=%h", k, obs_vec(), exp_v); end
      if (k == 2) rst_in = 1'b1;
      if (k == 3) rst_in = 1'b0;
    end
  endtask

  task automatic test_random();
    int kind, len;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      len  = (kind == 2) ? 4 : ((($urandom_range(0, 2)) == 0) ? 1 : ((($urandom_range(0, 1)) == 0) ? 2 : 4));
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      if (kind != 1) fill(addr, len);
      run_access(kind, addr, len, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk_in);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_priority();
    test_flush();
    test_bad_len();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
